uart_tx_engine: RTL
===================

# uart_tx_engine

UART serializer that converts 8-bit bytes from the chat-bot message sender into an asynchronous serial frame on `tx`. It sits between the chat-bot's byte output (`Byte_Out`/`Load_Byte`) and the board TX pin. It reports frame completion through `byte_sent`, which drives the chat-bot's `byte_has_been_sent` input. A one-entry holding register lets the next byte queue while the current frame shifts, so consecutive frames are sent with no idle gap.

## Interface
- `CLKS_PER_BIT`, 16 — clk cycles per serial bit; legal range ≥ 2.
- `clk` in 1 — clock; all logic is on the rising edge.
- `reset` in 1 — reset, synchronous, active-high.
- `load_byte` in 1 — single-cycle strobe; a byte is accepted when `load_byte`=1 and `ready`=1.
- `byte_in` in 8 — byte to send; sampled on an accepted strobe.
- `ready` out 1 — holding register empty; registered.
- `busy` out 1 — shifter active (START through STOP).
- `tx` out 1 — serial line; idles high.
- `byte_sent` out 1 — one-cycle pulse when a frame's stop bit completes.
- `overrun` out 1 — one-cycle pulse when `load_byte`=1 while `ready`=0; that byte is dropped.

## Operation
- Reset values: `tx`=1, `ready`=1, `busy`=0, `byte_sent`=0, `overrun`=0. The holding register is cleared, the FSM goes to IDLE, and all counters go to 0.
- Frame format: start bit 0, then 8 data bits LSB first, then one stop bit 1. Optional parity is described under Configuration.
- FSM states and transitions:
  - IDLE: if the holding register is full, move it into the shifter and go to START. `ready` goes to 1.
  - START → DATA → (PARITY) → STOP.
  - Each state lasts exactly `CLKS_PER_BIT` cycles. The baud counter runs 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - DATA uses a 3-bit bit counter 0..7 and leaves DATA after bit 7.
  - At the end of STOP, pulse `byte_sent`. If the holding register is full, go directly to START and reload the shifter at that same edge. Otherwise go to IDLE.
- Holding register handshake:
  - A strobe accepted at edge N sets `ready`=0 from the cycle after N.
  - `ready` returns to 1 on the cycle after the holding register's contents move into the shifter.
- Simultaneous strobe and reload in the same cycle: the strobe is judged against the registered `ready` value. If `ready`=0, the strobe counts as an overrun even though the register empties at that edge.
- `overrun` does not change `ready`, the holding register, or the frame in flight.
- Reset mid-frame: `tx`=1 from the next cycle, no `byte_sent` pulse, and the queued byte is discarded.

## Timing
- Latency when idle: strobe accepted at edge N, shifter loaded at N+1, `tx`=0 from the cycle after N+1.
- Frame length: 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- `byte_sent` is high for exactly the one cycle following the last STOP cycle.
- Back-to-back frames: the next start bit begins on the cycle right after the previous stop bit's final cycle, with no gap.
- `tx` is driven from a register; there is no combinational path from any input to `tx`.
- Baud counter width is `$clog2(CLKS_PER_BIT)`.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state is inserted between DATA and STOP. The parity bit is even parity, equal to the XOR of the 8 data bits. Frame length is 11 bits.
- Undefined: the PARITY state and its logic are absent. Frame length is 10 bits.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constants `UART_DATA_BITS`=8, `UART_START_LVL`=0, `UART_STOP_LVL`=1, `UART_IDLE_LVL`=1.
- Sub-module `uart_baud_counter` (parameter `CLKS_PER_BIT`; inputs `clk`, `reset`, `clear`; output `bit_done`).
  - `bit_done` pulses in the last cycle of each bit.
  - The FSM asserts `clear` when loading the shifter.

## Test plan
- Reset, then hold idle for 20 cycles → `tx`=1, `ready`=1, `busy`=0, no `byte_sent` or `overrun` pulses.
- `CLKS_PER_BIT`=4, strobe `byte_in`=0x61 → `tx` = 0, then 1,0,0,0,0,1,1,0, then 1, each level held 4 cycles (40 cycles total). `byte_sent` pulses once at the end.
- Strobe 0x68, then strobe 0x69 once `ready`=1 again → start of 0x69 immediately follows the stop bit of 0x68. Two `byte_sent` pulses 40 cycles apart.
- Strobe 0x41 and 0x42 to fill the shifter and holding register, then strobe 0x43 while `ready`=0 → `overrun` pulses once. Only 0x41 and 0x42 appear on `tx`.
- Assert `reset` during data bit 3 of 0xFF → `tx`=1 on the next cycle, `ready`=1, no `byte_sent` pulse. A fresh strobe then sends a full, correct frame.
- `UART_TX_PARITY_EN` defined, strobe 0x61 (three 1 bits) → parity bit 1 before stop, frame 44 cycles. Strobe 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;
    localparam logic UART_IDLE_LVL  = 1'b1;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign bit_done = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART byte serializer with a one-entry holding register for gapless frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_byte,
    input  logic [UART_DATA_BITS-1:0] byte_in,
    output logic                      ready,
    output logic                      busy,
    output logic                      tx,
    output logic                      byte_sent,
    output logic                      overrun
);

    uart_tx_state_t            r_state;
    logic [UART_DATA_BITS-1:0] r_hold;
    logic                      r_hold_full;
    logic                      r_ready;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [2:0]                r_bit_cnt;
    logic                      r_tx;
    logic                      r_busy;
    logic                      r_byte_sent;
    logic                      r_overrun;
`ifdef UART_TX_PARITY_EN
    logic                      r_parity;
`endif

    logic w_bit_done;
    logic w_accept;
    logic w_load;

    // Strobes are judged against the registered ready, even if the holding
    // register empties on the same edge.
    assign w_accept = load_byte && r_ready;
    assign w_load   = r_hold_full &&
                      ((r_state == IDLE) || ((r_state == STOP) && w_bit_done));

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_load),
        .bit_done (w_bit_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tx        <= UART_IDLE_LVL;
            r_busy      <= 1'b0;
            r_byte_sent <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_byte_sent <= 1'b0;
            r_overrun   <= load_byte && !r_ready;

            if (w_accept) begin
                r_hold      <= byte_in;
                r_hold_full <= 1'b1;
                r_ready     <= 1'b0;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
                r_ready     <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_tx   <= UART_IDLE_LVL;
                    r_busy <= 1'b0;
                end
                START: begin
                    if (w_bit_done) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_cnt == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= UART_STOP_LVL;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_done) begin
                        r_state <= STOP;
                        r_tx    <= UART_STOP_LVL;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_done) begin
                        r_byte_sent <= 1'b1;
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_tx        <= UART_IDLE_LVL;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= UART_IDLE_LVL;
                    r_busy  <= 1'b0;
                end
            endcase

            // Loading overrides the IDLE/STOP outcome above so a queued byte
            // starts on the very next bit period.
            if (w_load) begin
                r_shift <= r_hold;
                r_state <= START;
                r_tx    <= UART_START_LVL;
                r_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
                r_parity <= even_parity(r_hold);
`endif
            end
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign tx        = r_tx;
    assign byte_sent = r_byte_sent;
    assign overrun   = r_overrun;

endmodule
